// File: rtl/row_score_pkg.sv
// Shared types and helpers for the row score ranker.
// The state encoding and the row-score width rule live here.
package row_score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUM    = 2'd1,
    REPORT = 2'd2
  } state_e;

  // The widest row sum is 3*N, so the width must hold values 0..3*N.
  function automatic int score_width(input int n);
    return $clog2(3 * n + 1);
  endfunction

endpackage

// File: rtl/row_adder.sv
// Combinational row summer: N 2-bit entries reduced by a balanced adder tree.
// The leaf level is padded with zeros up to the next power of two.
module row_adder
  import row_score_pkg::*;
#(
  parameter int N  = 10,
  parameter int SW = score_width(N)
) (
  input  logic [N-1:0][1:0] row_i,
  output logic [SW-1:0]     sum_o
);

  localparam int LV = $clog2(N);
  localparam int P  = 1 << LV;

  logic [SW-1:0] tree_s [0:LV][0:P-1];

  // Partial sums never exceed the full row sum, so SW bits suffice at every level.
  always_comb begin
    for (int l = 0; l <= LV; l++) begin
      for (int j = 0; j < P; j++) begin
        tree_s[l][j] = '0;
      end
    end
    for (int j = 0; j < N; j++) begin
      tree_s[0][j] = SW'(row_i[j]);
    end
    for (int l = 1; l <= LV; l++) begin
      for (int j = 0; j < (P >> l); j++) begin
        tree_s[l][j] = tree_s[l-1][2*j] + tree_s[l-1][2*j+1];
      end
    end
  end

  assign sum_o = tree_s[LV][0];

endmodule

// File: rtl/row_score_ranker.sv
// Snapshots the N x N score matrix on a done rising edge, sums one row per cycle
// and reports the highest-scoring row (lowest index on ties) over valid/ready.
module row_score_ranker
  import row_score_pkg::*;
#(
  parameter int N  = 10,
  parameter int SW = score_width(N),
  parameter int IW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0][N-1:0][1:0] matrix_in,
  input  logic                     matrix_done,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [IW-1:0]            winner_idx,
  output logic [SW-1:0]            winner_score,
  output logic [N-1:0][SW-1:0]     row_scores,
  output logic                     busy
);

  state_e                     state_q, state_d;
  logic [N-1:0][N-1:0][1:0]   snapshot_q;
  logic                       done_q;
  logic                       pending_q;
  logic                       result_valid_q;
  logic                       busy_q;
  logic [IW-1:0]              row_ptr_q;
  logic [IW-1:0]              acc_idx_q;
  logic [SW-1:0]              acc_max_q;
  logic [IW-1:0]              winner_idx_q;
  logic [SW-1:0]              winner_score_q;
  logic [N-1:0][SW-1:0]       row_scores_q;

  logic                       start_s;
  logic                       handshake_s;
  logic                       restart_s;
  logic                       last_row_s;
  logic                       take_s;
  logic                       load_s;
  logic [SW-1:0]              row_sum_s;
  logic [SW-1:0]              max_d;
  logic [IW-1:0]              idx_d;

  row_adder #(
    .N  (N),
    .SW (SW)
  ) u_row_adder (
    .row_i (snapshot_q[row_ptr_q]),
    .sum_o (row_sum_s)
  );

  // A start seen at the handshake edge counts as pending; a restart needs done still high.
  always_comb begin
    start_s     = matrix_done & ~done_q;
    handshake_s = (state_q == REPORT) & result_valid_q & result_ready;
    restart_s   = handshake_s & (pending_q | start_s) & matrix_done;
    last_row_s  = (state_q == SUM) & (row_ptr_q == IW'(N - 1));
    take_s      = (row_sum_s > acc_max_q) | (row_ptr_q == '0);
    max_d       = take_s ? row_sum_s : acc_max_q;
    idx_d       = take_s ? row_ptr_q : acc_idx_q;
    load_s      = ((state_q == IDLE) & start_s) | restart_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) state_d = SUM;
        else         state_d = IDLE;
      end
      SUM: begin
        if (last_row_s) state_d = REPORT;
        else            state_d = SUM;
      end
      REPORT: begin
        if (restart_s)        state_d = SUM;
        else if (handshake_s) state_d = IDLE;
        else                  state_d = REPORT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; reset overrides everything, even mid-SUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot_q     <= '0;
      done_q         <= 1'b0;
      pending_q      <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      row_ptr_q      <= '0;
      acc_idx_q      <= '0;
      acc_max_q      <= '0;
      winner_idx_q   <= '0;
      winner_score_q <= '0;
      row_scores_q   <= '0;
    end else begin
      done_q         <= matrix_done;
      busy_q         <= (state_d != IDLE);
      result_valid_q <= (state_d == REPORT);

      if (handshake_s) begin
        pending_q <= 1'b0;
      end else if ((state_q != IDLE) && start_s) begin
        pending_q <= 1'b1;
      end

      if (load_s) begin
        snapshot_q <= matrix_in;
        row_ptr_q  <= '0;
        acc_max_q  <= '0;
        acc_idx_q  <= '0;
      end else if (state_q == SUM) begin
        row_scores_q[row_ptr_q] <= row_sum_s;
        acc_max_q               <= max_d;
        acc_idx_q               <= idx_d;
        row_ptr_q               <= row_ptr_q + IW'(1);
        if (last_row_s) begin
          winner_idx_q   <= idx_d;
          winner_score_q <= max_d;
        end
      end
    end
  end

  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign winner_idx   = winner_idx_q;
  assign winner_score = winner_score_q;
  assign row_scores   = row_scores_q;

endmodule

// File: tb/tb_row_score_ranker.sv
// Directed bench for row_score_ranker: expected results are computed from the
// driven matrix, queued at start time and compared when the result appears.
module tb_row_score_ranker;

  localparam int N  = 10;
  localparam int SW = 5;
  localparam int IW = 4;

  typedef logic [N-1:0][N-1:0][1:0] mat_t;
  typedef struct {
    int                   idx;
    int                   score;
    logic [N-1:0][SW-1:0] rows;
  } exp_t;

  logic                 clk;
  logic                 rst;
  mat_t                 matrix_in;
  logic                 matrix_done;
  logic                 result_valid;
  logic                 result_ready;
  logic [IW-1:0]        winner_idx;
  logic [SW-1:0]        winner_score;
  logic [N-1:0][SW-1:0] row_scores;
  logic                 busy;

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  exp_t last_e;
  int   cyc;
  int   vcount;

  row_score_ranker #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .matrix_in    (matrix_in),
    .matrix_done  (matrix_done),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .winner_idx   (winner_idx),
    .winner_score (winner_score),
    .row_scores   (row_scores),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input mat_t m);
    exp_t e;
    int   best;
    int   s;
    best   = -1;
    e.idx  = 0;
    e.score = 0;
    e.rows = '0;
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int c = 0; c < N; c++) s += int'(m[r][c]);
      e.rows[r] = SW'(s);
      if (s > best) begin
        best    = s;
        e.idx   = r;
        e.score = s;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (c < 3 * N) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (result_valid === 1'b1) break;
    end
    check("valid_within_budget", 256'(result_valid), 256'd1);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 256'd0, 256'd1);
    end else begin
      last_e = exp_q.pop_front();
      check({tag, "_winner_idx"},   256'(winner_idx),   256'(last_e.idx));
      check({tag, "_winner_score"}, 256'(winner_score), 256'(last_e.score));
      check({tag, "_row_scores"},   256'(row_scores),   256'(last_e.rows));
    end
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_valid_dropped"}, 256'(result_valid), 256'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    matrix_done  = 1'b0;
    result_ready = 1'b0;
    matrix_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_valid",        256'(result_valid), 256'd0);
    check("rst_busy",         256'(busy),         256'd0);
    check("rst_winner_idx",   256'(winner_idx),   256'd0);
    check("rst_winner_score", 256'(winner_score), 256'd0);
    check("rst_row_scores",   256'(row_scores),   256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic ranking with a tie between rows 3 and 7, then backpressure.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = 2'(r % 4);
    matrix_done = 1'b1;
    exp_q.push_back(model(matrix_in));
    @(posedge clk);
    @(negedge clk);
    check("t1_busy_after_start", 256'(busy),         256'd1);
    check("t1_valid_low_in_sum", 256'(result_valid), 256'd0);
    matrix_done = 1'b0;
    wait_valid(cyc);
    check("t1_latency", 256'(cyc), 256'(N));
    pop_check("t1");
    check("t1_tie_lowest_idx", 256'(winner_idx), 256'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_bp_valid", 256'(result_valid), 256'd1);
      check("t1_bp_idx",   256'(winner_idx),   256'(last_e.idx));
      check("t1_bp_score", 256'(winner_score), 256'(last_e.score));
      check("t1_bp_rows",  256'(row_scores),   256'(last_e.rows));
    end
    handshake("t1");
    check("t1_idle_busy", 256'(busy), 256'd0);

    // Snapshot isolation: matrix changes during SUM must not matter.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = 2'd3;
    matrix_done = 1'b1;
    exp_q.push_back(model(matrix_in));
    repeat (3) @(negedge clk);
    matrix_in   = '0;
    matrix_done = 1'b0;
    wait_valid(cyc);
    pop_check("t2");
    handshake("t2");
    check("t2_idle_busy", 256'(busy), 256'd0);

    // Pending restart: a second start during SUM restarts at the handshake.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = 2'(r % 4);
    matrix_done = 1'b1;
    exp_q.push_back(model(matrix_in));
    repeat (2) @(negedge clk);
    matrix_done = 1'b0;
    @(negedge clk);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = (r == 5) ? 2'd3 : 2'd0;
    matrix_done = 1'b1;
    exp_q.push_back(model(matrix_in));
    wait_valid(cyc);
    pop_check("t3a");
    handshake("t3a");
    check("t3_busy_restart", 256'(busy), 256'd1);
    wait_valid(cyc);
    check("t3_restart_latency", 256'(cyc), 256'(N));
    pop_check("t3b");
    handshake("t3b");
    check("t3_idle_busy", 256'(busy), 256'd0);
    matrix_done = 1'b0;
    @(negedge clk);

    // Pending cancelled: done drops before the handshake, so no second result.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = (r == 9) ? 2'd2 : 2'd1;
    matrix_done = 1'b1;
    exp_q.push_back(model(matrix_in));
    repeat (2) @(negedge clk);
    matrix_done = 1'b0;
    @(negedge clk);
    matrix_done = 1'b1;
    @(negedge clk);
    matrix_done = 1'b0;
    wait_valid(cyc);
    pop_check("t4");
    handshake("t4");
    check("t4_idle_busy", 256'(busy), 256'd0);
    vcount = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1 || busy === 1'b1) vcount++;
    end
    check("t4_no_second_round", 256'(vcount), 256'd0);

    // Reset mid-SUM, then a held done gives a fresh start right after release.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = 2'd3;
    matrix_done = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_valid",      256'(result_valid), 256'd0);
    check("t5_rst_busy",       256'(busy),         256'd0);
    check("t5_rst_winner_idx", 256'(winner_idx),   256'd0);
    check("t5_rst_score",      256'(winner_score), 256'd0);
    check("t5_rst_rows",       256'(row_scores),   256'd0);
    rst = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) matrix_in[r][c] = (r == 8) ? 2'd3 : 2'd1;
    exp_q.push_back(model(matrix_in));
    @(negedge clk);
    check("t5_fresh_start_busy", 256'(busy), 256'd1);
    wait_valid(cyc);
    check("t5_latency", 256'(cyc), 256'(N));
    pop_check("t5");
    handshake("t5");
    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
